imm_decode_buf: RTL

IMM_DECODE_BUF -- requirements
Module: imm_decode_buf

---
 rtl/imm_pkg.sv | 29 ++
 rtl/imm_decode_buf_if.sv | 24 ++
 rtl/imm_decode_buf_extend.sv | 79 +++++++
 rtl/imm_decode_buf.sv | 108 ++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared immediate-format codes and RISC-V major opcodes for the decode buffer.
// Imported by imm_extend and imm_decode_buf.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_Z    = 3'd6
    } imm_type_e;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam int unsigned DEPTH = 2;

endpackage

// File: rtl/imm_decode_buf_if.sv
// Producer/consumer handshake bundle of the immediate decode buffer.
// slave = buffer side, master = driver/consumer side.
interface imm_decode_buf_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_type;
    logic [31:0]     out_instr;

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_imm, out_type, out_instr
    );

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_imm, out_type, out_instr
    );
endinterface

// File: rtl/imm_decode_buf_extend.sv
// Combinational immediate extractor/extender (module imm_extend).
// Optional macro IMM_DECODE_CSR_EN enables the Z (CSR uimm) format.
module imm_extend
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm,
    output imm_type_e       o_type,
    output logic            o_unknown
);

    logic [31:0] w_imm32;

    // Opcode decode into a 32-bit immediate that is already sign-correct.
    always_comb begin
        w_imm32   = 32'd0;
        o_type    = IMM_NONE;
        o_unknown = 1'b0;
        case (i_instr[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
                o_type  = IMM_I;
                w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            end
            OPC_STORE: begin
                o_type  = IMM_S;
                w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            end
            OPC_BRANCH: begin
                o_type  = IMM_B;
                w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                           i_instr[30:25], i_instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                o_type  = IMM_U;
                w_imm32 = {i_instr[31:12], 12'd0};
            end
            OPC_JAL: begin
                o_type  = IMM_J;
                w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                           i_instr[20], i_instr[30:21], 1'b0};
            end
            OPC_OP: begin
                o_type = IMM_NONE;
            end
            OPC_OP_IMM_32: begin
                // The *W immediate forms only exist on RV64.
                if (XLEN == 64) begin
                    o_type  = IMM_I;
                    w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
                end else begin
                    o_unknown = 1'b1;
                end
            end
`ifdef IMM_DECODE_CSR_EN
            OPC_SYSTEM: begin
                if (i_instr[14]) begin
                    o_type  = IMM_Z;
                    w_imm32 = {27'd0, i_instr[19:15]};
                end else begin
                    o_type = IMM_NONE;
                end
            end
`else
            OPC_SYSTEM: begin
                o_type = IMM_NONE;
            end
`endif
            default: begin
                o_unknown = 1'b1;
            end
        endcase
    end

    // Signed cast widens with instr[31] (Z and NONE have a zero top bit).
    assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/imm_decode_buf.sv
// Two-entry decode buffer: extends immediates on the write path and counts unknown opcodes.
// Optional macro IMM_DECODE_CSR_EN (handled in imm_extend) adds the CSR Z format.
module imm_decode_buf
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    imm_decode_buf_if.slave  bus,
    output logic [CNT_W-1:0] unk_cnt
);

    logic [XLEN-1:0] r_imm   [DEPTH];
    imm_type_e       r_type  [DEPTH];
    logic [31:0]     r_instr [DEPTH];
    logic [1:0]      r_cnt;
    logic            r_wr_ptr;
    logic            r_rd_ptr;
    logic [CNT_W-1:0] r_unk_cnt;

    logic [XLEN-1:0] w_imm;
    imm_type_e       w_type;
    logic            w_unknown;
    logic            w_in_ready;
    logic            w_out_valid;
    logic            w_push;
    logic            w_pop;

    imm_extend #(.XLEN(XLEN)) u_extend (
        .i_instr   (bus.in_instr),
        .o_imm     (w_imm),
        .o_type    (w_type),
        .o_unknown (w_unknown)
    );

    assign w_in_ready  = (r_cnt != 2'd2);
    assign w_out_valid = (r_cnt != 2'd0);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign unk_cnt       = r_unk_cnt;

    // Head entry is only exposed while the buffer holds something.
    always_comb begin
        bus.out_imm   = '0;
        bus.out_type  = 3'd0;
        bus.out_instr = 32'd0;
        if (w_out_valid) begin
            bus.out_imm   = r_imm[r_rd_ptr];
            bus.out_type  = r_type[r_rd_ptr];
            bus.out_instr = r_instr[r_rd_ptr];
        end else begin
            bus.out_imm   = '0;
            bus.out_type  = 3'd0;
            bus.out_instr = 32'd0;
        end
    end

    // Entry storage, written at the tail on an accepted, unflushed push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_imm[i]   <= '0;
                r_type[i]  <= IMM_NONE;
                r_instr[i] <= 32'd0;
            end
        end else if (w_push && !flush) begin
            r_imm[r_wr_ptr]   <= w_imm;
            r_type[r_wr_ptr]  <= w_type;
            r_instr[r_wr_ptr] <= bus.in_instr;
        end
    end

    // Occupancy, pointers and the saturating unknown-opcode counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= 2'd0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_unk_cnt <= '0;
        end else if (flush) begin
            r_cnt    <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
            if (w_push && w_unknown && (r_unk_cnt != {CNT_W{1'b1}})) begin
                r_unk_cnt <= r_unk_cnt + CNT_W'(1);
            end
        end
    end

endmodule
